// File: rtl/tpu_commit_unit_pkg.sv
// Shared types for the TPU in-order commit tracker: window size, issue-number
// type and the commit FSM encoding.
package pkg_tpu;

    localparam int DEPTH_BUFF = 16;
    localparam int WIDTH_BUFF = $clog2(DEPTH_BUFF);

    typedef logic [WIDTH_BUFF-1:0] issue_no_t;
    typedef logic [WIDTH_BUFF:0]   count_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } commit_fsm_t;

endpackage

// File: rtl/tpu_commit_unit.sv
// In-order commit tracker: records issues, collects scalar/vector completions and
// retires one entry per cycle in issue order. Optional TPU_COMMIT_STATS_EN adds a commit counter.
module tpu_commit_unit
    import pkg_tpu::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        I_Issue_Req,
    input  issue_no_t   I_Issue_No,
    input  logic        I_Done_S_Req,
    input  issue_no_t   I_Done_S_No,
    input  logic        I_Done_V_Req,
    input  issue_no_t   I_Done_V_No,
    input  logic        I_Flush,
    output logic        O_Commit_Req,
    output issue_no_t   O_Commit_No,
    output logic        O_Full,
    output logic        O_Empty,
    output logic        O_Busy,
    output logic        O_Err,
    output logic [31:0] O_Num_Commit
);

    logic [DEPTH_BUFF-1:0] r_valid;
    logic [DEPTH_BUFF-1:0] r_done;
    logic [DEPTH_BUFF-1:0] w_valid_nxt;
    logic [DEPTH_BUFF-1:0] w_done_nxt;
    issue_no_t             r_head;
    count_t                r_count;
    commit_fsm_t           r_state;
    commit_fsm_t           w_state_nxt;
    logic                  r_commit_req;
    issue_no_t             r_commit_no;
    logic                  r_err;

    logic w_run;
    logic w_flush_clr;
    logic w_commit;
    logic w_full;
    logic w_issue_err;
    logic w_ds_err;
    logic w_dv_err;
    logic w_issue_ok;
    logic w_ds_ok;
    logic w_dv_ok;
    logic w_err_evt;
    logic w_busy;

    assign w_run       = (r_state == ST_RUN);
    assign w_flush_clr = (w_run && I_Flush) || (r_state == ST_FLUSH);
    assign w_commit    = w_run && r_valid[r_head] && r_done[r_head];
    assign w_full      = (r_count == count_t'(DEPTH_BUFF));

    // An issue may reuse the head slot only when that slot retires on the same edge.
    assign w_issue_err = I_Issue_Req &&
                         ((r_valid[I_Issue_No] && !(w_commit && (I_Issue_No == r_head))) ||
                          (w_full && !w_commit));
    assign w_ds_err    = I_Done_S_Req &&
                         (!r_valid[I_Done_S_No] || (I_Issue_Req && (I_Done_S_No == I_Issue_No)));
    assign w_dv_err    = I_Done_V_Req &&
                         (!r_valid[I_Done_V_No] || (I_Issue_Req && (I_Done_V_No == I_Issue_No)));

    assign w_issue_ok  = !w_flush_clr && I_Issue_Req  && !w_issue_err;
    assign w_ds_ok     = !w_flush_clr && I_Done_S_Req && !w_ds_err;
    assign w_dv_ok     = !w_flush_clr && I_Done_V_Req && !w_dv_err;
    assign w_err_evt   = !w_flush_clr && (w_issue_err || w_ds_err || w_dv_err);

    // Order matters: completions, then retirement clear, then the new issue wins its slot.
    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        if (w_ds_ok) w_done_nxt[I_Done_S_No] = 1'b1;
        if (w_dv_ok) w_done_nxt[I_Done_V_No] = 1'b1;
        if (w_commit) begin
            w_valid_nxt[r_head] = 1'b0;
            w_done_nxt[r_head]  = 1'b0;
        end
        if (w_issue_ok) begin
            w_valid_nxt[I_Issue_No] = 1'b1;
            w_done_nxt[I_Issue_No]  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (I_Flush) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_FLUSH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_count      <= '0;
            r_commit_req <= 1'b0;
            r_commit_no  <= '0;
            r_err        <= 1'b0;
        end else if (w_flush_clr) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_count      <= '0;
            r_commit_req <= 1'b0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_done       <= w_done_nxt;
            r_commit_req <= w_commit;
            r_count      <= r_count + count_t'(w_issue_ok) - count_t'(w_commit);
            r_err        <= r_err | w_err_evt;
            if (w_commit) begin
                r_commit_no <= r_head;
                r_head      <= r_head + issue_no_t'(1);
            end
        end
    end

`ifdef TPU_COMMIT_STATS_EN
    logic [31:0] r_num_commit;

    // Counts retirement pulses; survives flush, saturates rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num_commit <= '0;
        end else if (r_commit_req && (r_num_commit != 32'hFFFF_FFFF)) begin
            r_num_commit <= r_num_commit + 32'd1;
        end
    end

    assign O_Num_Commit = r_num_commit;
`else
    assign O_Num_Commit = 32'd0;
`endif

    assign O_Commit_Req = r_commit_req;
    assign O_Commit_No  = r_commit_no;
    assign O_Full       = w_full;
    assign O_Empty      = (r_count == '0);
    assign O_Busy       = w_busy;
    assign O_Err        = r_err;

endmodule

// File: tb/tb_tpu_commit_unit.sv
// Directed bench for tpu_commit_unit: issue numbers go into an expected-commit
// queue and a negedge monitor checks each commit pulse against it.
module tb_tpu_commit_unit;
    import pkg_tpu::*;

    logic        clock;
    logic        reset;
    logic        I_Issue_Req;
    issue_no_t   I_Issue_No;
    logic        I_Done_S_Req;
    issue_no_t   I_Done_S_No;
    logic        I_Done_V_Req;
    issue_no_t   I_Done_V_No;
    logic        I_Flush;
    logic        O_Commit_Req;
    issue_no_t   O_Commit_No;
    logic        O_Full;
    logic        O_Empty;
    logic        O_Busy;
    logic        O_Err;
    logic [31:0] O_Num_Commit;

    int checks   = 0;
    int failures = 0;
    issue_no_t exp_q[$];

    tpu_commit_unit dut (
        .clock        (clock),
        .reset        (reset),
        .I_Issue_Req  (I_Issue_Req),
        .I_Issue_No   (I_Issue_No),
        .I_Done_S_Req (I_Done_S_Req),
        .I_Done_S_No  (I_Done_S_No),
        .I_Done_V_Req (I_Done_V_Req),
        .I_Done_V_No  (I_Done_V_No),
        .I_Flush      (I_Flush),
        .O_Commit_Req (O_Commit_Req),
        .O_Commit_No  (O_Commit_No),
        .O_Full       (O_Full),
        .O_Empty      (O_Empty),
        .O_Busy       (O_Busy),
        .O_Err        (O_Err),
        .O_Num_Commit (O_Num_Commit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        I_Issue_Req  = 1'b0;
        I_Issue_No   = '0;
        I_Done_S_Req = 1'b0;
        I_Done_S_No  = '0;
        I_Done_V_Req = 1'b0;
        I_Done_V_No  = '0;
        I_Flush      = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic issue(input int n, input bit push);
        I_Issue_Req = 1'b1;
        I_Issue_No  = issue_no_t'(n);
        if (push) exp_q.push_back(issue_no_t'(n));
        cyc();
    endtask

    task automatic done_s(input int n);
        I_Done_S_Req = 1'b1;
        I_Done_S_No  = issue_no_t'(n);
        cyc();
    endtask

    task automatic done_v(input int n);
        I_Done_V_Req = 1'b1;
        I_Done_V_No  = issue_no_t'(n);
        cyc();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) cyc();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Scoreboard: every commit pulse must match the oldest outstanding issue.
    always @(negedge clock) begin
        if (!reset && O_Commit_Req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", O_Commit_No, 32'hDEAD);
            end else begin
                chk("commit_no", O_Commit_No, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        chk("rst_commit_req", O_Commit_Req, 0);
        chk("rst_commit_no",  O_Commit_No,  0);
        chk("rst_full",       O_Full,       0);
        chk("rst_empty",      O_Empty,      1);
        chk("rst_busy",       O_Busy,       0);
        chk("rst_err",        O_Err,        0);
        chk("rst_num_commit", O_Num_Commit, 0);
        cyc();
        reset = 1'b0;

        // Out-of-order completion, in-order retirement, two-edge latency
        issue(0, 1); issue(1, 1); issue(2, 1);
        done_s(2);
        done_v(1);
        done_s(0);
        chk("lat_edge_n_req", O_Commit_Req, 0);
        cyc();
        chk("lat_edge_n1_req", O_Commit_Req, 1);
        chk("lat_edge_n1_no",  O_Commit_No,  0);
        cyc();
        chk("seq_req1", O_Commit_Req, 1);
        chk("seq_no1",  O_Commit_No,  1);
        cyc();
        chk("seq_req2", O_Commit_Req, 1);
        chk("seq_no2",  O_Commit_No,  2);
        chk("seq_empty", O_Empty, 1);
        cyc();
        chk("seq_req_idle", O_Commit_Req, 0);

        // Dual completion in one cycle, head at 3
        issue(3, 1); issue(4, 1);
        I_Done_S_Req = 1'b1; I_Done_S_No = 3;
        I_Done_V_Req = 1'b1; I_Done_V_No = 4;
        cyc();
        cyc();
        chk("dual_no3", O_Commit_No, 3);
        cyc();
        chk("dual_req4", O_Commit_Req, 1);
        chk("dual_no4",  O_Commit_No,  4);
        chk("dual_empty", O_Empty, 1);

        // Advance head to 15, then wrap
        for (int i = 5; i < 15; i++) issue(i, 1);
        for (int i = 5; i < 15; i++) done_s(i);
        wait_drain("drain_to15");
        issue(15, 1); issue(0, 1);
        done_v(0);
        done_s(15);
        cyc();
        chk("wrap_no15", O_Commit_No, 15);
        cyc();
        chk("wrap_req0", O_Commit_Req, 1);
        chk("wrap_no0",  O_Commit_No,  0);
        issue(1, 1);
        done_s(1);
        wait_drain("wrap_head1");
        chk("wrap_err", O_Err, 0);

        // Stats: 10 commits, flush over pending work, 2 commits
        do_reset();
        for (int i = 0; i < 10; i++) issue(i, 1);
        for (int i = 0; i < 10; i++) done_v(i);
        wait_drain("stats_first10");
        for (int i = 10; i < 15; i++) issue(i, 1);
        done_s(11);
        done_v(12);
        done_s(10);
        I_Flush = 1'b1;
        exp_q.delete();
        cyc();
        chk("flush_no_commit", O_Commit_Req, 0);
        chk("flush_busy",      O_Busy,       1);
        chk("flush_empty",     O_Empty,      1);
        I_Issue_Req = 1'b1; I_Issue_No = 7;
        I_Done_S_Req = 1'b1; I_Done_S_No = 13;
        cyc();
        chk("post_flush_busy",  O_Busy,       0);
        chk("post_flush_empty", O_Empty,      1);
        chk("post_flush_err",   O_Err,        0);
        chk("post_flush_req",   O_Commit_Req, 0);
        issue(0, 1);
        done_s(0);
        wait_drain("flush_head0");
        issue(1, 1);
        done_v(1);
        wait_drain("flush_head1");
        cyc();
`ifdef TPU_COMMIT_STATS_EN
        chk("num_commit", O_Num_Commit, 12);
`else
        chk("num_commit", O_Num_Commit, 0);
`endif

        // Fill the window from head 2, then overflow
        for (int k = 0; k < DEPTH_BUFF; k++) issue((2 + k) % DEPTH_BUFF, 1);
        chk("fill_full",  O_Full,  1);
        chk("fill_empty", O_Empty, 0);
        chk("fill_err",   O_Err,   0);
        issue(5, 0);
        chk("ovf_err",  O_Err,  1);
        chk("ovf_full", O_Full, 1);
        for (int k = DEPTH_BUFF - 1; k >= 0; k--) done_s((2 + k) % DEPTH_BUFF);
        wait_drain("fill_drain");
        chk("fill_drain_empty", O_Empty, 1);

        // Done to an invalid entry
        do_reset();
        chk("err_cleared", O_Err, 0);
        done_s(3);
        chk("err_done_invalid", O_Err, 1);

        // Done aimed at the entry issued the same cycle is dropped
        do_reset();
        I_Issue_Req = 1'b1; I_Issue_No = 0;
        I_Done_V_Req = 1'b1; I_Done_V_No = 0;
        exp_q.push_back(issue_no_t'(0));
        cyc();
        chk("err_done_on_issue", O_Err, 1);
        cyc(); cyc(); cyc();
        chk("dropped_done_empty", O_Empty, 0);
        chk("dropped_done_req",   O_Commit_Req, 0);
        done_s(0);
        wait_drain("dropped_done_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
